// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an internal baud divider and a
// valid/ready word interface. Frame: start bit, DATA_BITS data bits sent
// LSB first, optional odd/even parity bit, STOP_BITS stop bits.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   tx_valid_i  upstream has a word on tx_data_i
//   tx_data_i   payload, sampled only on the handshake edge
//   tx_ready_o  block can accept a word (high only in IDLE)
//   tx_o        serial line, idle high, registered
//   tx_busy_o   frame in progress
//   tx_done_o   one-cycle pulse on the edge the frame completes
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration rather than clamping them.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    // Last cycle of the current bit; the next bit is launched on this edge.
    logic bit_end_c;
    assign bit_end_c = (baud_q == CNT_MAX);

    // Frame sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Baud counter free-runs inside a frame and restarts on each bit launch.
            if (state_q != S_IDLE) begin
                baud_q <= bit_end_c ? '0 : baud_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (tx_valid_i && ready_q) begin
                        shift_q  <= tx_data_i;
                        // Odd parity inverts the XOR so the total count of ones is odd.
                        parity_q <= (PARITY == 1) ? ~(^tx_data_i) : (^tx_data_i);
                        state_q  <= S_START;
                        baud_q   <= '0;
                        idx_q    <= '0;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end_c) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end

                S_DATA: begin
                    if (bit_end_c) begin
                        if (idx_q == DATA_LAST) begin
                            idx_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end

                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= S_STOP;
                        idx_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end

                S_STOP: begin
                    // idx_q is reused to count stop bits.
                    if (bit_end_c) begin
                        if (idx_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;
    assign tx_busy_o  = busy_q;
    assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param. Four instances cover no parity, even
// parity, odd parity and a 5-bit / 2-stop-bit frame, all at 4 clocks per bit.
// Expected line levels are queued per clock when a word is sent and popped as
// the serial line is sampled on the falling edge.
module tb_uart_tx_param;

    localparam int unsigned C = 4;

    logic       clk;
    logic       rst;
    logic [3:0] valid_r;
    logic [8:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] rdy_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int vectors;
    int errors;
    logic exp_q [$];

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .rst(rst), .tx_valid_i(valid_r[0]), .tx_data_i(data_r[0][7:0]),
        .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_o(done_w[0]));

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_valid_i(valid_r[1]), .tx_data_i(data_r[1][7:0]),
        .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_o(done_w[1]));

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_valid_i(valid_r[2]), .tx_data_i(data_r[2][7:0]),
        .tx_ready_o(rdy_w[2]), .tx_o(tx_w[2]), .tx_busy_o(busy_w[2]), .tx_done_o(done_w[2]));

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_five (
        .clk(clk), .rst(rst), .tx_valid_i(valid_r[3]), .tx_data_i(data_r[3][4:0]),
        .tx_ready_o(rdy_w[3]), .tx_o(tx_w[3]), .tx_busy_o(busy_w[3]), .tx_done_o(done_w[3]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one word on instance d starting at a falling edge, checks the whole
    // frame and the completion edge, and returns at the falling edge after it.
    task automatic frame(input int d, input logic [8:0] word, input int nbits,
                         input int par, input int nstop, input logic keep,
                         input logic [8:0] nxt, input bit noise);
        int   f;
        logic p;
        logic e;
        p = 1'b0;
        for (int j = 0; j < nbits; j++) p = p ^ word[j];
        if (par == 1) p = ~p;
        for (int j = 0; j < int'(C); j++) exp_q.push_back(1'b0);
        for (int b = 0; b < nbits; b++)
            for (int j = 0; j < int'(C); j++) exp_q.push_back(word[b]);
        if (par != 0)
            for (int j = 0; j < int'(C); j++) exp_q.push_back(p);
        for (int j = 0; j < nstop * int'(C); j++) exp_q.push_back(1'b1);
        f = exp_q.size();

        valid_r[d] = 1'b1;
        data_r[d]  = word;
        chk($sformatf("ready_pre d%0d", d), rdy_w[d], 1'b1);
        next_cycle();
        valid_r[d] = keep;
        data_r[d]  = nxt;
        for (int i = 0; i < f; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("tx d%0d w%0h c%0d", d, word, i), tx_w[d], e);
            chk($sformatf("ready_low d%0d c%0d", d, i), rdy_w[d], 1'b0);
            chk($sformatf("busy d%0d c%0d", d, i), busy_w[d], 1'b1);
            chk($sformatf("done_low d%0d c%0d", d, i), done_w[d], 1'b0);
            if (noise && i < f - 1) begin
                valid_r[d] = 1'($urandom);
                data_r[d]  = 9'($urandom);
            end else if (noise) begin
                valid_r[d] = keep;
                data_r[d]  = nxt;
            end
            next_cycle();
        end
        chk($sformatf("done_pulse d%0d", d), done_w[d], 1'b1);
        chk($sformatf("ready_end d%0d", d), rdy_w[d], 1'b1);
        chk($sformatf("busy_end d%0d", d), busy_w[d], 1'b0);
        chk($sformatf("tx_end d%0d", d), tx_w[d], 1'b1);
    endtask

    initial begin
        int pulses;
        clk     = 1'b0;
        rst     = 1'b1;
        valid_r = '0;
        for (int i = 0; i < 4; i++) data_r[i] = '0;
        vectors = 0;
        errors  = 0;

        // Reset state of every instance
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_tx d%0d", d), tx_w[d], 1'b1);
            chk($sformatf("rst_ready d%0d", d), rdy_w[d], 1'b1);
            chk($sformatf("rst_busy d%0d", d), busy_w[d], 1'b0);
            chk($sformatf("rst_done d%0d", d), done_w[d], 1'b0);
        end
        rst = 1'b0;
        next_cycle();

        // 8N1, 0xA5
        frame(0, 9'h0A5, 8, 0, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();
        chk("done_one_cycle", done_w[0], 1'b0);

        // Parity variants
        frame(1, 9'h0A5, 8, 2, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();
        frame(2, 9'h0A5, 8, 1, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();
        frame(1, 9'h001, 8, 2, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();

        // 5 data bits, 2 stop bits; upper data bits are dropped
        frame(3, 9'h0FF, 5, 0, 2, 1'b0, 9'h000, 1'b0);
        next_cycle();
        frame(3, 9'h1E0, 5, 0, 2, 1'b0, 9'h000, 1'b0);
        next_cycle();

        // Back-to-back stream with tx_valid held high
        frame(0, 9'h011, 8, 0, 1, 1'b1, 9'h022, 1'b0);
        frame(0, 9'h022, 8, 0, 1, 1'b1, 9'h033, 1'b0);
        frame(0, 9'h033, 8, 0, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();
        chk("stream_done_clear", done_w[0], 1'b0);
        chk("stream_idle", busy_w[0], 1'b0);

        // Reset during data bit 3 of 0xA5
        valid_r[0] = 1'b1;
        data_r[0]  = 9'h0A5;
        next_cycle();
        valid_r[0] = 1'b0;
        repeat (17) next_cycle();
        chk("pre_rst_bit3", tx_w[0], 1'b0);
        chk("pre_rst_busy", busy_w[0], 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("midrst_tx", tx_w[0], 1'b1);
        chk("midrst_ready", rdy_w[0], 1'b1);
        chk("midrst_busy", busy_w[0], 1'b0);
        chk("midrst_done", done_w[0], 1'b0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done_w[0] === 1'b1 || tx_w[0] !== 1'b1) pulses++;
            next_cycle();
        end
        chk("midrst_quiet", 1'(pulses != 0), 1'b0);
        frame(0, 9'h05A, 8, 0, 1, 1'b0, 9'h000, 1'b0);
        next_cycle();

        // Input noise mid-frame must not disturb the stream
        frame(1, 9'h03C, 8, 2, 1, 1'b0, 9'h000, 1'b1);
        next_cycle();
        chk("noise_no_restart", busy_w[1], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
